// File: rtl/alu_cluster_pkg.sv
// alu_cluster_pkg: opcodes, instruction-width helper and the shared ALU function.
// alu_exec returns {err, result}; the result is masked to the given result width.
package alu_cluster_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_NOT = 4'd7,
    OP_LS  = 4'd8,
    OP_RS  = 4'd9
  } op_e;

  localparam int MAXW = 32;

  function automatic int iw_of(input int opw);
    return 4 + 2 * opw;
  endfunction

  function automatic logic [MAXW:0] alu_exec(
    input logic [3:0]      op,
    input logic [MAXW-1:0] a,
    input logic [MAXW-1:0] b,
    input int              opw,
    input int              resw
  );
    logic [MAXW-1:0] rm;
    logic [MAXW-1:0] om;
    logic [MAXW-1:0] r;
    logic            e;
    rm = {MAXW{1'b1}} >> (MAXW - resw);
    om = {MAXW{1'b1}} >> (MAXW - opw);
    r  = '0;
    e  = 1'b0;
    case (op)
      OP_ADD: r = a + b;
      OP_SUB: r = a - b;
      OP_MUL: r = a * b;
      OP_DIV: begin
        if (b == '0) begin
          r = rm;
          e = 1'b1;
        end else begin
          r = a / b;
        end
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a & om;
      OP_LS:  r = a << 1;
      OP_RS:  r = a >> 1;
      default: e = 1'b1;
    endcase
    return {e, r & rm};
  endfunction

endpackage

// File: rtl/alu_cluster_core.sv
// alu_core: instruction FIFO, pop control, one-stage ALU and result register.
// Ports: push/push_instr in, res_ready drains result; count/empty/full status out.
module alu_core
  import alu_cluster_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int OPW        = 4,
  parameter int RESW       = 8,
  localparam int IW        = iw_of(OPW),
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [IW-1:0]   push_instr,
  input  logic            res_ready,
  output logic [CW-1:0]   count,
  output logic            empty,
  output logic            full,
  output logic            res_valid,
  output logic [RESW-1:0] res_data,
  output logic            res_err
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [IW-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            pop;
  logic [IW-1:0]   head;
  logic [3:0]      op;
  logic [OPW-1:0]  a;
  logic [OPW-1:0]  b;
  logic [MAXW:0]   ex;
  logic            ex_unused;

  assign empty = (count == '0);
  assign full  = (count == CW'(FIFO_DEPTH));
  assign pop   = !empty && (!res_valid || res_ready);

  assign head = mem[rd_ptr];
  assign op   = head[IW-1 -: 4];
  assign a    = head[2*OPW-1 -: OPW];
  assign b    = head[OPW-1:0];
  assign ex   = alu_exec(op, MAXW'(a), MAXW'(b), OPW, RESW);
  assign ex_unused = ^ex[MAXW-1:RESW];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_instr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (pop) begin
        res_valid <= 1'b1;
        res_data  <= ex[RESW-1:0];
        res_err   <= ex[MAXW];
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_cluster.sv
// alu_cluster: least-loaded dispatch into NUM_CORES alu_core instances,
// round-robin result merge onto out_*, plus FIFO status and total_level.
module alu_cluster
  import alu_cluster_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int OPW        = 4,
  parameter int RESW       = 8,
  localparam int IW        = iw_of(OPW),
  localparam int CIW       = $clog2(NUM_CORES),
  localparam int TLW       = $clog2(NUM_CORES * FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [IW-1:0]        in_instr,
  output logic                 in_ready,
  input  logic [NUM_CORES-1:0] core_disable,
  output logic                 out_valid,
  output logic [RESW-1:0]      out_result,
  output logic                 out_err,
  output logic [CIW-1:0]       out_core,
  input  logic                 out_ready,
  output logic [NUM_CORES-1:0] core_empty,
  output logic [NUM_CORES-1:0] core_full,
  output logic [TLW-1:0]       total_level
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [CW-1:0]        cnt [NUM_CORES];
  logic [RESW-1:0]      rd  [NUM_CORES];
  logic [NUM_CORES-1:0] rv;
  logic [NUM_CORES-1:0] re;
  logic [NUM_CORES-1:0] push_v;
  logic [NUM_CORES-1:0] drain_v;
  logic [NUM_CORES-1:0] elig;
  logic [CIW-1:0]       sel;
  logic [CIW-1:0]       rr_idx;
  logic [CIW-1:0]       grant;
  logic [CIW-1:0]       last_grant;
  logic [CIW-1:0]       lock_idx;
  logic                 lock;
  logic                 hs;

  // Least-loaded pick; strict < keeps the lowest index on ties.
  always_comb begin
    logic [CW-1:0] best;
    logic          found;
    elig  = ~core_disable & ~core_full;
    sel   = '0;
    best  = '1;
    found = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (elig[CIW'(i)] && (!found || cnt[CIW'(i)] < best)) begin
        found = 1'b1;
        best  = cnt[CIW'(i)];
        sel   = CIW'(i);
      end
    end
  end

  assign in_ready = |elig;

  // Round-robin from last_grant+1; a stalled grant is held so the
  // presented result cannot switch under the consumer.
  always_comb begin
    logic found;
    int   idx;
    found  = 1'b0;
    idx    = 0;
    rr_idx = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      idx = (int'(last_grant) + k) % NUM_CORES;
      if (!found && rv[CIW'(idx)]) begin
        found  = 1'b1;
        rr_idx = CIW'(idx);
      end
    end
    grant = lock ? lock_idx : rr_idx;
  end

  assign out_valid  = |rv;
  assign hs         = out_valid & out_ready;
  assign out_result = out_valid ? rd[grant] : '0;
  assign out_err    = out_valid ? re[grant] : 1'b0;
  assign out_core   = out_valid ? grant : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= CIW'(NUM_CORES - 1);
      lock       <= 1'b0;
      lock_idx   <= '0;
    end else begin
      if (hs) last_grant <= grant;
      lock     <= out_valid & ~out_ready;
      lock_idx <= grant;
    end
  end

  always_comb begin
    total_level = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      total_level = total_level + TLW'(cnt[CIW'(i)]);
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    assign push_v[g]  = in_valid & in_ready & (sel == CIW'(g));
    assign drain_v[g] = hs & (grant == CIW'(g));

    alu_core #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .OPW        (OPW),
      .RESW       (RESW)
    ) u_core (
      .clk        (clk),
      .rst        (rst),
      .push       (push_v[g]),
      .push_instr (in_instr),
      .res_ready  (drain_v[g]),
      .count      (cnt[g]),
      .empty      (core_empty[g]),
      .full       (core_full[g]),
      .res_valid  (rv[g]),
      .res_data   (rd[g]),
      .res_err    (re[g])
    );
  end

endmodule

// File: tb/tb_alu_cluster.sv
// tb_alu_cluster: directed stimulus with a scoreboard queue of expected results;
// a negedge monitor matches each output handshake against the queue.
module tb_alu_cluster;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid;
  logic [11:0] in_instr;
  logic        in_ready;
  logic [3:0]  core_disable;
  logic        out_valid;
  logic [7:0]  out_result;
  logic        out_err;
  logic [1:0]  out_core;
  logic        out_ready;
  logic [3:0]  core_empty;
  logic [3:0]  core_full;
  logic [5:0]  total_level;

  always #5 clk = ~clk;

  alu_cluster dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_instr     (in_instr),
    .in_ready     (in_ready),
    .core_disable (core_disable),
    .out_valid    (out_valid),
    .out_result   (out_result),
    .out_err      (out_err),
    .out_core     (out_core),
    .out_ready    (out_ready),
    .core_empty   (core_empty),
    .core_full    (core_full),
    .total_level  (total_level)
  );

  typedef struct {
    logic [3:0] mask;
    logic [7:0] res;
    logic       err;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int outs = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen here completes at the next posedge.
  always @(negedge clk) begin
    int hit;
    hit = -1;
    if (!rst && out_valid && out_ready) begin
      for (int j = 0; j < q.size(); j++) begin
        if (hit < 0 && q[j].mask[out_core] &&
            q[j].res == out_result && q[j].err == out_err)
          hit = j;
      end
      checks++;
      outs++;
      if (hit < 0) begin
        failures++;
        $display("FAIL out_match actual core=%0d result=%0h err=%0b required=a queued entry",
                 out_core, out_result, out_err);
      end else begin
        q.delete(hit);
      end
    end
  end

  task automatic issue(input logic [11:0] ins, input logic [3:0] m,
                       input logic [7:0] r, input logic e);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = ins;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("issue_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    q.push_back('{mask: m, res: r, err: e});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk(name, 32'(q.size()), 32'd0);
  endtask

  function automatic logic [11:0] fvec(input int i);
    if (i < 16) return {4'h0, 4'(i), 4'h0};
    if (i < 31) return {4'h0, 4'hF, 4'(i - 15)};
    return {4'h2, 4'hF, 4'(i - 28)};
  endfunction

  function automatic logic [7:0] fval(input int i);
    if (i < 31) return 8'(i);
    return 8'(15 * (i - 28));
  endfunction

  logic [11:0] av [12] = '{12'h370, 12'h2FF, 12'hA00, 12'h135,
                           12'h4CA, 12'h5CA, 12'h6CA, 12'h7C0,
                           12'h8F0, 12'h9F0, 12'h3C3, 12'hF12};
  logic [7:0]  ar [12] = '{8'hFF, 8'hE1, 8'h00, 8'hFE,
                           8'h08, 8'h0E, 8'h06, 8'h03,
                           8'h1E, 8'h07, 8'h04, 8'h00};
  logic        ae [12] = '{1'b1, 1'b0, 1'b1, 1'b0,
                           1'b0, 1'b0, 1'b0, 1'b0,
                           1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int outs0;
    in_valid     = 1'b0;
    in_instr     = '0;
    core_disable = '0;
    out_ready    = 1'b1;
    rst          = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", 32'(out_result), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_out_core", 32'(out_core), 32'd0);
    chk("rst_total_level", 32'(total_level), 32'd0);
    chk("rst_core_empty", 32'(core_empty), 32'hF);
    chk("rst_core_full", 32'(core_full), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    core_disable = 4'hF;
    #1;
    chk("rst_in_ready_dis", 32'(in_ready), 32'd0);
    core_disable = 4'h0;
    #1;
    rst = 1'b0;

    // ADD 3,5 and its latency
    issue(12'h035, 4'b0001, 8'h08, 1'b0);
    chk("lat_t_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_t1_valid", 32'(out_valid), 32'd1);
    chk("lat_t1_core", 32'(out_core), 32'd0);
    chk("lat_t1_result", 32'(out_result), 32'h08);
    wait_drain("drain_add");

    // ALU vectors, all steered to core 0
    core_disable = 4'b1110;
    for (int i = 0; i < 12; i++) issue(av[i], 4'b0001, ar[i], ae[i]);
    wait_drain("drain_alu");

    // Cores 0/1 disabled, then everything disabled while results drain
    core_disable = 4'b0011;
    out_ready    = 1'b0;
    issue(12'h011, 4'b1100, 8'h02, 1'b0);
    issue(12'h012, 4'b1100, 8'h03, 1'b0);
    issue(12'h013, 4'b1100, 8'h04, 1'b0);
    issue(12'h014, 4'b1100, 8'h05, 1'b0);
    chk("dis_total_level", 32'(total_level), 32'd2);
    chk("dis_core_empty01", 32'(core_empty[1:0]), 32'h3);
    core_disable = 4'hF;
    #1;
    chk("all_dis_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    wait_drain("drain_disabled");
    chk("dis_drained_level", 32'(total_level), 32'd0);
    core_disable = 4'h0;

    // Fresh arbiter: prime each result register, then dispatch order
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      core_disable = ~(4'b0001 << k);
      issue(12'h088 + 12'(k), 4'b0001 << k, 8'h10 + 8'(k), 1'b0);
    end
    core_disable = 4'h0;
    issue(12'h258, 4'b0001, 8'h28, 1'b0);
    issue(12'h259, 4'b0010, 8'h2D, 1'b0);
    issue(12'h25A, 4'b0100, 8'h32, 1'b0);
    issue(12'h25B, 4'b1000, 8'h37, 1'b0);
    @(negedge clk);
    chk("rr_total_level", 32'(total_level), 32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rr_core_%0d", i), 32'(out_core), 32'(i % 4));
      @(negedge clk);
    end
    wait_drain("drain_rr");

    // Fill every FIFO and result register, then drain
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      in_instr = fvec(acc);
      in_valid = 1'b1;
      if (in_ready) begin
        q.push_back('{mask: 4'hF, res: fval(acc), err: 1'b0});
        acc++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("fill_accepted", 32'(acc), 32'd36);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_total_level", 32'(total_level), 32'd32);
    chk("fill_core_full", 32'(core_full), 32'hF);
    outs0 = outs;
    out_ready = 1'b1;
    wait_drain("drain_fill");
    chk("fill_drain_count", 32'(outs - outs0), 32'd36);

    // Asynchronous reset with work in flight
    out_ready = 1'b0;
    issue(12'h011, 4'hF, 8'h02, 1'b0);
    issue(12'h012, 4'hF, 8'h03, 1'b0);
    issue(12'h013, 4'hF, 8'h04, 1'b0);
    chk("pre_rst_level", 32'(total_level), 32'd1);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_level", 32'(total_level), 32'd0);
    chk("async_rst_empty", 32'(core_empty), 32'hF);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    issue(12'h6F0, 4'b0001, 8'h0F, 1'b0);
    wait_drain("drain_post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
